keyboard_calc_top: RTL and testbench
====================================

# keyboard_calc_top

Top level of the keypad adding calculator. It scans a 4x4 matrix keypad and produces one press pulse and a scan code per new key. Digit keys are entered into one of two 6-digit BCD operand buffers. Each buffer is converted to binary, and the two operands are summed continuously for display logic downstream.

## Interface
Parameters: none. Widths are fixed: 6 digits, 20-bit operands, 21-bit sum.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- kc_sel  in  4  column sense, active-low; bit c low means column c is closed
- kr_sel  out  4  row drive, one-hot-low; bit r low means row r is driven
- press  out  1  one-cycle pulse marking a new valid key
- scan_code  out  4  code of the last detected key, {row[1:0], col[1:0]}
- buf_flag_1  out  6  digit-valid mask of operand 1, bit 0 = newest digit
- key_buf_code_1  out  24  operand 1 as 6 BCD digits, [3:0] = least significant
- buf_flag_2  out  6  digit-valid mask of operand 2
- key_buf_code_2  out  24  operand 2 as 6 BCD digits
- add_1  out  20  binary value of key_buf_code_1
- add_2  out  20  binary value of key_buf_code_2
- sum  out  21  add_1 + add_2

## Operation
- **Scanner.** kr_sel rotates each clock: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - A kc_sel value is valid only if exactly one bit is 0 (1110, 1101, 1011 or 0111).
  - 0000, 1111 and multi-zero patterns mean no key.
  - While a valid pattern is sensed, kr_sel holds. It resumes rotating when the pattern goes away.
- **New press.** A new press occurs when kc_sel is valid this cycle and was not valid on the previous cycle.
  - scan_code = {index of the low kr_sel bit, index of the low kc_sel bit}.
  - A held key produces exactly one press.
- **Key map.**
  - 0x0–0x9: digit.
  - 0xA: select operand 2.
  - 0xB: select operand 1.
  - 0xC: clear both buffers and select operand 1.
  - 0xD: backspace (see Configuration).
  - 0xE, 0xF: ignored.
- **Digit entry** into the active buffer:
  - code = {code[19:0], digit}
  - flag = {flag[4:0], 1'b1}
  - When flag[5] = 1 the buffer is full, and further digits are ignored.
- **Conversion.** add_x is the binary weight of the 6 BCD digits. Range is 0–999999.
- **Sum.** sum = add_1 + add_2, zero-extended, no overflow possible. Maximum is 1999998.
- **Reset values** (rst = 0 at a clock edge):
  - kr_sel = 1110, press = 0, scan_code = 0.
  - All flags and buffers 0; add_1 = add_2 = sum = 0.
  - Active operand = 1; previous-valid register = 0.
- A reset asserted during any operation overrides everything on that edge.

## Timing
- At edge N, kc_sel and kr_sel are sampled. If a new press is detected, press = 1 and scan_code are registered from edge N and held for one cycle. press returns to 0 at N+1.
- scan_code holds its value until the next press.
- Buffers and flags update at edge N+1, based on the registered press and scan_code.
- add_1, add_2 and sum are combinational from the buffers and are valid in the same cycle as the buffer update.
- A kc_sel pulse one cycle wide is enough to register a key.
- Back-to-back presses need at least one invalid cycle in between.

## Configuration
- KEYPAD_BACKSPACE_EN defined:
  - Key 0xD on a non-empty active buffer does code = {4'h0, code[23:4]} and flag = {1'b0, flag[5:1]}.
  - On an empty buffer it does nothing.
- KEYPAD_BACKSPACE_EN undefined: key 0xD is ignored, the same as 0xE and 0xF.

## Structure
- Shared package keyboard_pkg holds:
  - key-code constants KEY_OPND2 = 4'hA, KEY_OPND1 = 4'hB, KEY_CLR = 4'hC, KEY_BS = 4'hD
  - NUM_DIGITS = 6
  - operand and sum width constants
- Sub-module bcd6_to_bin: 24-bit BCD in, 20-bit binary out, combinational. Instantiated twice.
- Scanner, press detection and buffer control live in keyboard_calc_top.

## Test plan
- **Reset:** rst = 0 for 1 cycle, then rst = 1 -> kr_sel = 1110; all outputs 0; next edge kr_sel = 1101.
- **Digit entry:** keys 1, 2, 3 -> buf_flag_1 = 000111, key_buf_code_1 = 24'h000123, add_1 = 123, sum = 123.
- **Full buffer:** digits 1..7 -> key_buf_code_1 = 24'h123456, flag = 111111; the 7th digit is ignored; add_1 = 123456.
- **Operand 2:** after the previous case, keys A, 9, 9 -> key_buf_code_2 = 24'h000099, add_2 = 99, sum = 123555. Then 999999 in both operands -> sum = 1999998.
- **Held/invalid/clear:**
  - Key held 3 cycles -> exactly one press pulse.
  - kc_sel = 0000 or 1001 -> no press.
  - Key C -> all buffers, adds and sum = 0; active operand = 1.
- **Backspace** (macro defined): 1, 2, D -> key_buf_code_1 = 24'h000001, flag = 000001. Macro undefined: the buffer stays 24'h000012.

Source files
------------

// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared constants, types and helpers for the keypad adding calculator
package keyboard_pkg;
  localparam int NUM_DIGITS = 6;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int OPND_W = 20;
  localparam int SUM_W = 21;
  localparam logic [3:0] KEY_OPND2 = 4'hA;
  localparam logic [3:0] KEY_OPND1 = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_BS = 4'hD;
  typedef enum logic {OPND_1, OPND_2} opnd_t;
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/keyboard_calc_top_bcd6_to_bin.sv
// bcd6_to_bin: combinational 6-digit BCD to 20-bit binary conversion
module bcd6_to_bin
  import keyboard_pkg::*;
(
  input  logic [BCD_W-1:0]  bcd,
  output logic [OPND_W-1:0] bin
);
  // Horner evaluation from the most significant digit down
  always_comb begin
    bin = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      bin = OPND_W'(bin * OPND_W'(10)) + OPND_W'(bcd[4*i +: 4]);
  end
endmodule

// File: rtl/keyboard_calc_top.sv
// keyboard_calc_top: 4x4 keypad scanner feeding two BCD operand buffers and a binary adder (option: KEYPAD_BACKSPACE_EN)
module keyboard_calc_top
  import keyboard_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            kc_sel,
  output logic [3:0]            kr_sel,
  output logic                  press,
  output logic [3:0]            scan_code,
  output logic [NUM_DIGITS-1:0] buf_flag_1,
  output logic [BCD_W-1:0]      key_buf_code_1,
  output logic [NUM_DIGITS-1:0] buf_flag_2,
  output logic [BCD_W-1:0]      key_buf_code_2,
  output logic [OPND_W-1:0]     add_1,
  output logic [OPND_W-1:0]     add_2,
  output logic [SUM_W-1:0]      sum
);
  logic valid, prev_valid, new_press;
  opnd_t opnd;
  logic [BCD_W-1:0] act_code, nxt_code;
  logic [NUM_DIGITS-1:0] act_flag, nxt_flag;
  logic dig_ok, bs_ok, wr;
  assign valid = kc_sel inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign new_press = valid && !prev_valid;
  // Row rotation, held while a key is sensed; one press per valid episode
  always_ff @(posedge clk) begin
    if (!rst) begin
      kr_sel <= 4'b1110;
      prev_valid <= 1'b0;
      press <= 1'b0;
      scan_code <= 4'h0;
    end else begin
      kr_sel <= valid ? kr_sel : {kr_sel[2:0], kr_sel[3]};
      prev_valid <= valid;
      press <= new_press;
      if (new_press) scan_code <= {low_idx(kr_sel), low_idx(kc_sel)};
    end
  end
  // Next value of the active buffer for a digit or backspace key
  always_comb begin
    act_code = opnd == OPND_2 ? key_buf_code_2 : key_buf_code_1;
    act_flag = opnd == OPND_2 ? buf_flag_2 : buf_flag_1;
    dig_ok = scan_code <= 4'd9 && !act_flag[NUM_DIGITS-1];
`ifdef KEYPAD_BACKSPACE_EN
    bs_ok = scan_code == KEY_BS && act_flag[0];
`else
    bs_ok = 1'b0;
`endif
    nxt_code = bs_ok ? {4'h0, act_code[BCD_W-1:4]} : {act_code[BCD_W-5:0], scan_code};
    nxt_flag = bs_ok ? {1'b0, act_flag[NUM_DIGITS-1:1]} : {act_flag[NUM_DIGITS-2:0], 1'b1};
    wr = press && (dig_ok || bs_ok);
  end
  // Buffer control driven by the registered press and scan code
  always_ff @(posedge clk) begin
    if (!rst || (press && scan_code == KEY_CLR)) begin
      opnd <= OPND_1;
      buf_flag_1 <= '0;
      key_buf_code_1 <= '0;
      buf_flag_2 <= '0;
      key_buf_code_2 <= '0;
    end else begin
      if (press && scan_code == KEY_OPND2) opnd <= OPND_2;
      if (press && scan_code == KEY_OPND1) opnd <= OPND_1;
      if (wr && opnd == OPND_1) begin
        key_buf_code_1 <= nxt_code;
        buf_flag_1 <= nxt_flag;
      end
      if (wr && opnd == OPND_2) begin
        key_buf_code_2 <= nxt_code;
        buf_flag_2 <= nxt_flag;
      end
    end
  end
  bcd6_to_bin u_conv_1 (.bcd(key_buf_code_1), .bin(add_1));
  bcd6_to_bin u_conv_2 (.bcd(key_buf_code_2), .bin(add_2));
  assign sum = {1'b0, add_1} + {1'b0, add_2};
endmodule

// File: tb/tb_keyboard_calc_top.sv
// tb_keyboard_calc_top: table-driven key sequences plus hand-written scanner corner cases
module tb_keyboard_calc_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] kc_sel = 4'hF;
  logic [3:0] kr_sel, scan_code;
  logic press;
  logic [5:0] buf_flag_1, buf_flag_2;
  logic [23:0] key_buf_code_1, key_buf_code_2;
  logic [19:0] add_1, add_2;
  logic [20:0] sum;
  int checks = 0;
  int errors = 0;
  int press_cnt = 0;

  keyboard_calc_top dut (
    .clk(clk), .rst(rst), .kc_sel(kc_sel), .kr_sel(kr_sel), .press(press),
    .scan_code(scan_code), .buf_flag_1(buf_flag_1), .key_buf_code_1(key_buf_code_1),
    .buf_flag_2(buf_flag_2), .key_buf_code_2(key_buf_code_2),
    .add_1(add_1), .add_2(add_2), .sum(sum)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (press === 1'b1) press_cnt++;

  typedef struct {
    logic [3:0]  key;
    logic [23:0] c1;
    logic [5:0]  f1;
    logic [23:0] c2;
    logic [5:0]  f2;
    logic [19:0] a1;
    logic [19:0] a2;
    logic [20:0] s;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] k, input logic [23:0] c1, input logic [5:0] f1,
                         input logic [23:0] c2, input logic [5:0] f2,
                         input logic [19:0] a1, input logic [19:0] a2, input logic [20:0] s);
    vec_t v;
    v.key = k; v.c1 = c1; v.f1 = f1; v.c2 = c2; v.f2 = f2; v.a1 = a1; v.a2 = a2; v.s = s;
    vecs.push_back(v);
  endtask

  task automatic wait_row(input logic [1:0] row);
    int n = 0;
    while (kr_sel[row] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL wait_row %0d: row never driven, kr_sel %b", row, kr_sel);
    end
  endtask

  task automatic press_key(input logic [3:0] k);
    @(negedge clk);
    wait_row(k[3:2]);
    kc_sel = ~(4'b0001 << k[1:0]);
    @(negedge clk);
    kc_sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pc;
    logic [3:0] kr_prev;
    add_vec(4'h1, 24'h000001, 6'h01, 24'h0, 6'h0,      1,     0,      1);
    add_vec(4'h2, 24'h000012, 6'h03, 24'h0, 6'h0,     12,     0,     12);
    add_vec(4'h3, 24'h000123, 6'h07, 24'h0, 6'h0,    123,     0,    123);
    add_vec(4'h4, 24'h001234, 6'h0F, 24'h0, 6'h0,   1234,     0,   1234);
    add_vec(4'h5, 24'h012345, 6'h1F, 24'h0, 6'h0,  12345,     0,  12345);
    add_vec(4'h6, 24'h123456, 6'h3F, 24'h0, 6'h0, 123456,     0, 123456);
    add_vec(4'h7, 24'h123456, 6'h3F, 24'h0, 6'h0, 123456,     0, 123456);
    add_vec(4'hA, 24'h123456, 6'h3F, 24'h0, 6'h0, 123456,     0, 123456);
    add_vec(4'h9, 24'h123456, 6'h3F, 24'h000009, 6'h01, 123456, 9, 123465);
    add_vec(4'h9, 24'h123456, 6'h3F, 24'h000099, 6'h03, 123456, 99, 123555);
    add_vec(4'hE, 24'h123456, 6'h3F, 24'h000099, 6'h03, 123456, 99, 123555);
    add_vec(4'hC, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'h0, 24'h000000, 6'h01, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'h8, 24'h000008, 6'h03, 24'h0, 6'h0, 8, 0, 8);
    add_vec(4'hC, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'hD, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'h1, 24'h000001, 6'h01, 24'h0, 6'h0, 1, 0, 1);
    add_vec(4'h2, 24'h000012, 6'h03, 24'h0, 6'h0, 12, 0, 12);
`ifdef KEYPAD_BACKSPACE_EN
    add_vec(4'hD, 24'h000001, 6'h01, 24'h0, 6'h0, 1, 0, 1);
`else
    add_vec(4'hD, 24'h000012, 6'h03, 24'h0, 6'h0, 12, 0, 12);
`endif
    add_vec(4'hC, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'hA, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'h5, 24'h0, 6'h0, 24'h000005, 6'h01, 0, 5, 5);
    add_vec(4'hB, 24'h0, 6'h0, 24'h000005, 6'h01, 0, 5, 5);
    add_vec(4'h7, 24'h000007, 6'h01, 24'h000005, 6'h01, 7, 5, 12);
    add_vec(4'hC, 24'h0, 6'h0, 24'h0, 6'h0, 0, 0, 0);
    add_vec(4'h9, 24'h000009, 6'h01, 24'h0, 6'h0, 9, 0, 9);
    add_vec(4'h9, 24'h000099, 6'h03, 24'h0, 6'h0, 99, 0, 99);
    add_vec(4'h9, 24'h000999, 6'h07, 24'h0, 6'h0, 999, 0, 999);
    add_vec(4'h9, 24'h009999, 6'h0F, 24'h0, 6'h0, 9999, 0, 9999);
    add_vec(4'h9, 24'h099999, 6'h1F, 24'h0, 6'h0, 99999, 0, 99999);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h0, 6'h0, 999999, 0, 999999);
    add_vec(4'hA, 24'h999999, 6'h3F, 24'h0, 6'h0, 999999, 0, 999999);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h000009, 6'h01, 999999, 9, 1000008);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h000099, 6'h03, 999999, 99, 1000098);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h000999, 6'h07, 999999, 999, 1000998);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h009999, 6'h0F, 999999, 9999, 1009998);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h099999, 6'h1F, 999999, 99999, 1099998);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h999999, 6'h3F, 999999, 999999, 1999998);
    add_vec(4'h9, 24'h999999, 6'h3F, 24'h999999, 6'h3F, 999999, 999999, 1999998);

    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset kr_sel", kr_sel, 4'b1110);
    chk("reset press", press, 0);
    chk("reset scan_code", scan_code, 0);
    chk("reset flags", {buf_flag_1, buf_flag_2}, 0);
    chk("reset codes", {key_buf_code_1, key_buf_code_2}, 0);
    chk("reset sum", sum, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset rotate", kr_sel, 4'b1101);

    foreach (vecs[i]) begin
      pc = press_cnt;
      press_key(vecs[i].key);
      chk($sformatf("v%0d press count", i), press_cnt - pc, 1);
      chk($sformatf("v%0d scan_code", i), scan_code, vecs[i].key);
      chk($sformatf("v%0d code1", i), key_buf_code_1, vecs[i].c1);
      chk($sformatf("v%0d flag1", i), buf_flag_1, vecs[i].f1);
      chk($sformatf("v%0d code2", i), key_buf_code_2, vecs[i].c2);
      chk($sformatf("v%0d flag2", i), buf_flag_2, vecs[i].f2);
      chk($sformatf("v%0d add_1", i), add_1, vecs[i].a1);
      chk($sformatf("v%0d add_2", i), add_2, vecs[i].a2);
      chk($sformatf("v%0d sum", i), sum, vecs[i].s);
    end

    press_key(4'hC);
    @(negedge clk);
    wait_row(2'd1);
    kr_prev = kr_sel;
    pc = press_cnt;
    kc_sel = 4'b1101;
    repeat (3) @(negedge clk);
    chk("held kr_sel holds", kr_sel, kr_prev);
    kc_sel = 4'hF;
    repeat (2) @(negedge clk);
    chk("held one press", press_cnt - pc, 1);
    chk("held scan_code", scan_code, 4'h5);
    chk("held code1", key_buf_code_1, 24'h000005);
    chk("held flag1", buf_flag_1, 6'h01);

    pc = press_cnt;
    kc_sel = 4'b0000;
    repeat (3) @(negedge clk);
    kc_sel = 4'b1001;
    kr_prev = kr_sel;
    @(negedge clk);
    chk("invalid rotates", kr_sel, {kr_prev[2:0], kr_prev[3]});
    repeat (2) @(negedge clk);
    kc_sel = 4'hF;
    repeat (2) @(negedge clk);
    chk("invalid no press", press_cnt - pc, 0);
    chk("invalid code1", key_buf_code_1, 24'h000005);

    press_key(4'h3);
    chk("pre-reset code1", key_buf_code_1, 24'h000053);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid reset code1", key_buf_code_1, 0);
    chk("mid reset flag1", buf_flag_1, 0);
    chk("mid reset scan", scan_code, 0);
    chk("mid reset kr_sel", kr_sel, 4'b1110);
    press_key(4'h6);
    chk("post reset operand1", key_buf_code_1, 24'h000006);
    chk("post reset operand2", key_buf_code_2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
